mxint_block_quantize: RTL and testbench
=======================================

MXINT_BLOCK_QUANTIZE -- requirements
Module: mxint_block_quantize

Interface
REQ-001 IN_SIZE, default 4: elements per block.
REQ-002 IN_WIDTH, default 16: signed two's-complement input element width.
REQ-003 MAN_WIDTH, default 8: signed output mantissa width; legal range 2 <= MAN_WIDTH <= IN_WIDTH.
REQ-004 EXP_WIDTH, default $clog2(IN_WIDTH): unsigned shared-exponent width.
REQ-005 clk  input  1: the single clock; all state on its rising edge.
REQ-006 rst  input  1: asynchronous, active-low reset.
REQ-007 data_in  input  IN_WIDTH x IN_SIZE: signed input block.
REQ-008 data_in_valid  input  1: the block on data_in is valid.
REQ-009 data_in_ready  output  1: the block accepts data_in.
REQ-010 mdata_out  output  MAN_WIDTH x IN_SIZE: signed quantized mantissas.
REQ-011 edata_out  output  EXP_WIDTH: shared exponent E.
REQ-012 data_out_valid  output  1: mdata_out and edata_out are valid.
REQ-013 data_out_ready  input  1: the downstream stage accepts the output.

Function
REQ-014 A transfer occurs on any rising edge where valid and ready are both 1, on either side.
REQ-015 The block SHALL be a 3-stage pipeline (S1, S2, S3), each stage holding one block plus a valid bit.
REQ-016 S1 SHALL register the raw block and OR = bitwise OR of abs(data_in[i]) over all i.
  - abs(x) is ~x+1 when x < 0, otherwise x.
  - abs(-2^(IN_WIDTH-1)) wraps to itself.
REQ-017 S2 SHALL register the raw block and E = index of the highest set bit of OR; E = 0 when OR = 0.
REQ-018 S3 SHALL register the mantissas and E; edata_out = E.
  - Shift s = E - (MAN_WIDTH-2), signed.
  - s >= 0: mantissa = x arithmetic-shifted right by s (floor).
  - s < 0: mantissa = x shifted left by -s.
REQ-019 Mantissas SHALL be clamped to the symmetric range [-(2^(MAN_WIDTH-1)-1), 2^(MAN_WIDTH-1)-1]; -2^(MAN_WIDTH-1) becomes -(2^(MAN_WIDTH-1)-1).
REQ-020 Intermediate arithmetic SHALL be at least IN_WIDTH+MAN_WIDTH bits wide so that no left shift overflows before the clamp.
REQ-021 Each stage SHALL advance when it is empty or when the stage after it advances.
  - S3 advances when data_out_ready = 1.
  - data_in_ready = !S1.valid OR S1 advances. This is combinational and depends on data_out_ready.
REQ-022 Latency SHALL be 3 cycles, from acceptance to data_out_valid, with no back-pressure; throughput is 1 block per cycle.
REQ-023 Blocks SHALL leave in acceptance order; none is dropped or duplicated.
REQ-024 While data_out_valid = 1 and data_out_ready = 0, mdata_out, edata_out and data_out_valid SHALL hold stable.
REQ-025 When full under back-pressure, exactly 3 blocks SHALL be held and data_in_ready SHALL be 0.
REQ-026 When the pipeline is full and data_out_ready = 1, the block SHALL accept a new input in the same cycle as the output transfer.
REQ-027 data_out_valid SHALL be S3.valid, with no combinational path from data_in_valid.

Reset
REQ-028 While rst = 0, all stage valid bits SHALL be 0 and data_out_valid SHALL be 0.
REQ-029 While rst = 0, mdata_out and edata_out SHALL be 0 and data_in_ready SHALL be 1.
REQ-030 Asserting rst mid-operation SHALL discard all in-flight blocks immediately, without waiting for a clock edge.
REQ-031 After rst is released, the first accepted block SHALL appear 3 cycles later.

Verification (IN_SIZE=4, IN_WIDTH=16, MAN_WIDTH=8; shift s = E-6)
REQ-032 {100,-3,7,0}, data_out_ready held 1 -> 3 cycles later E=6, mant {100,-3,7,0}.
REQ-033 {1000,-1000,5,-5} -> E=9, mant {125,-125,0,-1}; {-1023,0,0,0} -> E=9, mant {-127,0,0,0} (clamp).
REQ-034 {3,1,0,-2} -> E=1, mant {96,32,0,-64}; {0,0,0,0} -> E=0, mant 0; {-32768,0,0,0} -> E=15, mant {-64,0,0,0}.
REQ-035 data_out_ready=0, five blocks offered back-to-back -> three accepted, data_in_ready=0, output held stable; data_out_ready=1 -> five blocks out in order, one per cycle.
REQ-036 Random valid/ready toggling, 10k blocks, compared against a reference model -> all blocks match, in order, no loss.
REQ-037 rst=0 asserted between clock edges with two blocks in flight -> data_out_valid=0 at once; after release, only new blocks emerge.

Source files
------------

// File: rtl/mxint_block_quantize.sv
// Block quantizer: a block of signed integers becomes signed mantissas
// that share one exponent. Three-stage valid/ready pipeline:
//   S1 registers the block and the OR of the element magnitudes,
//   S2 turns that OR into the shared exponent,
//   S3 shifts, clamps and registers the mantissas.
module mxint_block_quantize #(
   parameter int IN_SIZE   = 4,
   parameter int IN_WIDTH  = 16,
   parameter int MAN_WIDTH = 8,
   parameter int EXP_WIDTH = $clog2(IN_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  data_in [IN_SIZE],
   input  logic                 data_in_valid,
   output logic                 data_in_ready,
   output logic [MAN_WIDTH-1:0] mdata_out [IN_SIZE],
   output logic [EXP_WIDTH-1:0] edata_out,
   output logic                 data_out_valid,
   input  logic                 data_out_ready
);

   // Wide enough that the largest left shift (exponent 0) cannot overflow
   // before the clamp sees the value.
   localparam int WW   = IN_WIDTH + MAN_WIDTH;
   localparam int BIAS = MAN_WIDTH - 2;
   localparam logic signed [WW-1:0] MAN_MAX = WW'((1 << (MAN_WIDTH - 1)) - 1);
   localparam logic signed [WW-1:0] MAN_MIN = -MAN_MAX;

   logic                 s1_valid_reg, s2_valid_reg, s3_valid_reg;
   logic [IN_WIDTH-1:0]  s1_data_reg [IN_SIZE];
   logic [IN_WIDTH-1:0]  s2_data_reg [IN_SIZE];
   logic [IN_WIDTH-1:0]  s1_or_reg;
   logic [EXP_WIDTH-1:0] s2_exp_reg, s3_exp_reg;
   logic [MAN_WIDTH-1:0] s3_man_reg [IN_SIZE];

   logic                 s1_adv, s2_adv, s3_adv;
   logic [IN_WIDTH-1:0]  abs_val [IN_SIZE];
   logic [IN_WIDTH-1:0]  or_next;
   logic [EXP_WIDTH-1:0] exp_next;
   logic [MAN_WIDTH-1:0] man_next [IN_SIZE];

   // A stage moves when it is empty or its successor moves; the ready
   // chain is purely combinational from data_out_ready back to the input.
   always_comb begin
      s3_adv = !s3_valid_reg || data_out_ready;
      s2_adv = !s2_valid_reg || s3_adv;
      s1_adv = !s1_valid_reg || s2_adv;
   end

   assign data_in_ready  = s1_adv;
   assign data_out_valid = s3_valid_reg;
   assign edata_out      = s3_exp_reg;
   assign mdata_out      = s3_man_reg;

   // Magnitudes; the most negative value wraps to itself, which still
   // carries the correct top bit for the exponent search.
   for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_abs
      assign abs_val[gi] = data_in[gi][IN_WIDTH-1] ? (~data_in[gi] + IN_WIDTH'(1))
                                                   : data_in[gi];
   end

   // OR of all magnitudes has the same leading one as the largest magnitude.
   always_comb begin
      or_next = '0;
      for (int i = 0; i < IN_SIZE; i++) or_next = or_next | abs_val[i];
   end

   // Leading-one position of the OR; zero block gives exponent 0.
   always_comb begin
      exp_next = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (s1_or_reg[i]) exp_next = EXP_WIDTH'(i);
      end
   end

   // Per element: shift by (E - BIAS) in either direction, then clamp to
   // the symmetric mantissa range.
   for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_man
      logic signed [WW-1:0] wide;
      logic signed [WW-1:0] shifted;
      logic signed [WW-1:0] clamped;
      always_comb begin
         wide = {{MAN_WIDTH{s2_data_reg[gi][IN_WIDTH-1]}}, s2_data_reg[gi]};
         if (int'(s2_exp_reg) >= BIAS)
            shifted = wide >>> (int'(s2_exp_reg) - BIAS);
         else
            shifted = wide <<< (BIAS - int'(s2_exp_reg));
         if (shifted > MAN_MAX)
            clamped = MAN_MAX;
         else if (shifted < MAN_MIN)
            clamped = MAN_MIN;
         else
            clamped = shifted;
         man_next[gi] = clamped[MAN_WIDTH-1:0];
      end
   end

   // Stage 1: capture the raw block and the magnitude OR.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_reg <= 1'b0;
         s1_or_reg    <= '0;
         for (int i = 0; i < IN_SIZE; i++) s1_data_reg[i] <= '0;
      end else if (s1_adv) begin
         s1_valid_reg <= data_in_valid;
         s1_or_reg    <= or_next;
         s1_data_reg  <= data_in;
      end
   end

   // Stage 2: carry the raw block forward alongside its shared exponent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid_reg <= 1'b0;
         s2_exp_reg   <= '0;
         for (int i = 0; i < IN_SIZE; i++) s2_data_reg[i] <= '0;
      end else if (s2_adv) begin
         s2_valid_reg <= s1_valid_reg;
         s2_exp_reg   <= exp_next;
         s2_data_reg  <= s1_data_reg;
      end
   end

   // Stage 3: output register; holds while downstream stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s3_valid_reg <= 1'b0;
         s3_exp_reg   <= '0;
         for (int i = 0; i < IN_SIZE; i++) s3_man_reg[i] <= '0;
      end else if (s3_adv) begin
         s3_valid_reg <= s2_valid_reg;
         s3_exp_reg   <= s2_exp_reg;
         s3_man_reg   <= man_next;
      end
   end

endmodule

// File: tb/tb_mxint_block_quantize.sv
// Directed and randomized checks for mxint_block_quantize with
// IN_SIZE=4, IN_WIDTH=16, MAN_WIDTH=8 (exponent bias 6).
module tb_mxint_block_quantize;

   localparam int N  = 4;
   localparam int IW = 16;
   localparam int MW = 8;
   localparam int EW = 4;
   localparam int OW = EW + N * MW;
   localparam int NB = 10000;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] data_in [N];
   logic          data_in_valid;
   logic          data_in_ready;
   logic [MW-1:0] mdata_out [N];
   logic [EW-1:0] edata_out;
   logic          data_out_valid;
   logic          data_out_ready;

   int checks = 0;
   int errors = 0;

   // Directed vectors and hand-computed results.
   int vin  [6][4] = '{'{100, -3, 7, 0}, '{1000, -1000, 5, -5}, '{-1023, 0, 0, 0},
                       '{3, 1, 0, -2}, '{0, 0, 0, 0}, '{-32768, 0, 0, 0}};
   int vexp [6]    = '{6, 9, 9, 1, 0, 15};
   int vman [6][4] = '{'{100, -3, 7, 0}, '{125, -125, 0, -1}, '{-127, 0, 0, 0},
                       '{96, 32, 0, -64}, '{0, 0, 0, 0}, '{-64, 0, 0, 0}};

   always #5 clk = ~clk;

   mxint_block_quantize #(
      .IN_SIZE(N), .IN_WIDTH(IW), .MAN_WIDTH(MW), .EXP_WIDTH(EW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .data_in(data_in),
      .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready),
      .mdata_out(mdata_out),
      .edata_out(edata_out),
      .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready)
   );

   function automatic logic [OW-1:0] pack_vals(input int e, input int m[4]);
      logic [OW-1:0] r;
      r = OW'(e & 15);
      for (int i = 0; i < N; i++) r = (r << MW) | OW'(m[i] & 255);
      return r;
   endfunction

   function automatic logic [OW-1:0] pack_dut();
      logic [OW-1:0] r;
      r = OW'(edata_out);
      for (int i = 0; i < N; i++) r = (r << MW) | OW'(mdata_out[i]);
      return r;
   endfunction

   // Reference model in plain integer arithmetic.
   function automatic logic [OW-1:0] model(input int x[4]);
      int maxabs, a, e, s, d, q;
      int m[4];
      maxabs = 0;
      for (int i = 0; i < N; i++) begin
         a = (x[i] < 0) ? -x[i] : x[i];
         if (a > maxabs) maxabs = a;
      end
      e = 0;
      while (e < IW - 1 && (1 << (e + 1)) <= maxabs) e++;
      s = e - (MW - 2);
      for (int i = 0; i < N; i++) begin
         if (s >= 0) begin
            d = 1 << s;
            q = x[i] / d;
            if (x[i] < 0 && (x[i] % d) != 0) q = q - 1;
         end else begin
            q = x[i] * (1 << (-s));
         end
         if (q > 127) q = 127;
         if (q < -127) q = -127;
         m[i] = q;
      end
      return pack_vals(e, m);
   endfunction

   task automatic drive_vec(input int k);
      for (int i = 0; i < N; i++) data_in[i] = IW'(vin[k][i]);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      data_out_ready = 1'b1;
      data_in_valid = 1'b1;
      drive_vec(0);
      repeat (3) @(negedge clk);
      checks++;
      if (data_out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got %b want 0", data_out_valid);
      end
      checks++;
      if (data_in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b want 1", data_in_ready);
      end
      checks++;
      if (pack_dut() !== '0) begin
         errors++; $display("FAIL reset_data got %h want 0", pack_dut());
      end
      $display("reset: valid=%b ready=%b out=%h", data_out_valid, data_in_ready, pack_dut());
      data_in_valid = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
   endtask

   // One block at a time: latency and value for each directed vector.
   task automatic test_vectors();
      data_out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         drive_vec(k);
         data_in_valid = 1'b1;
         @(negedge clk);
         data_in_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (data_out_valid !== 1'b0) begin
            errors++; $display("FAIL vec%0d_early got valid=%b want 0", k, data_out_valid);
         end
         @(negedge clk);
         checks++;
         if (data_out_valid !== 1'b1) begin
            errors++; $display("FAIL vec%0d_latency got valid=%b want 1", k, data_out_valid);
         end
         checks++;
         if (pack_dut() !== pack_vals(vexp[k], vman[k])) begin
            errors++;
            $display("FAIL vec%0d_value got %h want %h", k, pack_dut(), pack_vals(vexp[k], vman[k]));
         end
         $display("vec%0d: E=%0d mant=%0d %0d %0d %0d", k, edata_out, $signed(mdata_out[0]),
                  $signed(mdata_out[1]), $signed(mdata_out[2]), $signed(mdata_out[3]));
         @(negedge clk);
      end
   endtask

   // Fill under back-pressure, then drain with concurrent acceptance.
   task automatic test_back_to_back();
      int n;
      logic [OW-1:0] snap;
      n = 0;
      data_out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (n < 5) begin drive_vec(n); data_in_valid = 1'b1; end
         else data_in_valid = 1'b0;
         #1;
         if (data_in_valid && data_in_ready) n++;
         @(negedge clk);
      end
      if (n < 5) begin drive_vec(n); data_in_valid = 1'b1; end
      #1;
      checks++;
      if (n !== 3) begin errors++; $display("FAIL b2b_accepted got %0d want 3", n); end
      checks++;
      if (data_in_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_full_ready got %b want 0", data_in_ready);
      end
      checks++;
      if (data_out_valid !== 1'b1 || pack_dut() !== pack_vals(vexp[0], vman[0])) begin
         errors++; $display("FAIL b2b_head got v=%b %h want v=1 %h", data_out_valid, pack_dut(),
                            pack_vals(vexp[0], vman[0]));
      end
      snap = pack_dut();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (data_out_valid !== 1'b1 || pack_dut() !== snap) begin
         errors++; $display("FAIL b2b_hold got v=%b %h want v=1 %h", data_out_valid, pack_dut(), snap);
      end
      $display("b2b: held %0d blocks, out=%h", n, pack_dut());
      data_out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (n < 5) begin drive_vec(n); data_in_valid = 1'b1; end
         else data_in_valid = 1'b0;
         #1;
         if (k == 0) begin
            checks++;
            if (data_in_ready !== 1'b1) begin
               errors++; $display("FAIL b2b_concurrent_ready got %b want 1", data_in_ready);
            end
         end
         if (data_in_valid && data_in_ready) n++;
         checks++;
         if (data_out_valid !== 1'b1 || pack_dut() !== pack_vals(vexp[k], vman[k])) begin
            errors++; $display("FAIL b2b_out%0d got v=%b %h want v=1 %h", k, data_out_valid,
                               pack_dut(), pack_vals(vexp[k], vman[k]));
         end
         $display("b2b out%0d: %h", k, pack_dut());
         @(negedge clk);
      end
      data_in_valid = 1'b0;
      #1;
      checks++;
      if (n !== 5 || data_out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_drain got n=%0d v=%b want n=5 v=0", n, data_out_valid);
      end
      @(negedge clk);
   endtask

   // Asynchronous reset with two blocks in flight.
   task automatic test_midreset();
      int outs;
      data_out_ready = 1'b1;
      drive_vec(1); data_in_valid = 1'b1;
      @(negedge clk);
      drive_vec(2);
      @(negedge clk);
      data_in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (data_out_valid !== 1'b0 || data_in_ready !== 1'b1 || pack_dut() !== '0) begin
         errors++; $display("FAIL midreset got v=%b r=%b %h want v=0 r=1 0", data_out_valid,
                            data_in_ready, pack_dut());
      end
      $display("midreset: valid=%b ready=%b", data_out_valid, data_in_ready);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      drive_vec(3); data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      outs = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (data_out_valid) begin
            outs++;
            checks++;
            if (pack_dut() !== pack_vals(vexp[3], vman[3])) begin
               errors++; $display("FAIL midreset_new got %h want %h", pack_dut(),
                                  pack_vals(vexp[3], vman[3]));
            end
            $display("midreset out: %h", pack_dut());
         end
         @(negedge clk);
      end
      checks++;
      if (outs !== 1) begin errors++; $display("FAIL midreset_count got %0d want 1", outs); end
   endtask

   // Random valid/ready toggling against the reference model.
   task automatic test_random();
      logic [OW-1:0] q[$];
      logic [OW-1:0] expv;
      logic signed [IW-1:0] r;
      int cur[4];
      int sent, recv, cyc;
      sent = 0; recv = 0; cyc = 0;
      while (recv < NB && cyc < 90000) begin
         data_out_ready = ($urandom_range(0, 3) != 0);
         if (sent < NB && $urandom_range(0, 3) != 0) begin
            for (int i = 0; i < N; i++) begin
               r = IW'($urandom);
               r = r >>> $urandom_range(0, 15);
               cur[i] = int'(r);
               data_in[i] = r;
            end
            data_in_valid = 1'b1;
         end else begin
            data_in_valid = 1'b0;
         end
         #1;
         if (data_in_valid && data_in_ready) begin
            q.push_back(model(cur));
            sent++;
         end
         if (data_out_valid && data_out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rand_extra got %h want none", pack_dut());
            end else begin
               expv = q.pop_front();
               if (pack_dut() !== expv) begin
                  errors++; $display("FAIL rand%0d got %h want %h", recv, pack_dut(), expv);
               end
            end
            $display("rand%0d: %h", recv, pack_dut());
            recv++;
         end
         @(negedge clk);
         cyc++;
      end
      data_in_valid = 1'b0;
      checks++;
      if (recv !== NB || q.size() != 0) begin
         errors++; $display("FAIL rand_count got %0d left %0d want %0d left 0", recv, q.size(), NB);
      end
   endtask

   initial begin
      data_in_valid = 1'b0;
      data_out_ready = 1'b0;
      for (int i = 0; i < N; i++) data_in[i] = '0;
      test_reset();
      test_vectors();
      test_back_to_back();
      test_midreset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
